// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM and MEM/WB registers, data-memory req/ack
// access with load extension, store byte lanes and an ack timeout.
module mem_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  f3_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic        wb_reg_wr_i,
    output logic        stall_o,
    output logic [4:0]  exmem_rd_o,
    output logic [31:0] exmem_alu_o,
    output logic        exmem_wb_reg_wr_o,
    output logic [4:0]  memwb_rd_o,
    output logic [31:0] memwb_wdata_o,
    output logic        memwb_wb_reg_wr_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [1:0]  dbg_state
);

    // Handshake: dmem_req_o rises in ACCESS and stays high with we/addr/wdata/be
    // stable until the cycle in which dmem_ack_i=1 is seen; ack outside ACCESS is ignored.

    localparam int CW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   ex_alu, ex_wdata;
    logic [4:0]    ex_rd;
    logic [2:0]    ex_f3;
    logic          ex_mem_rd, ex_mem_wr, ex_wb;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic [31:0]   ld_data_q;

    logic          memop, misaligned;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;

    // Control bits are stored already qualified by valid, so a bubble is all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_alu    <= '0;
            ex_wdata  <= '0;
            ex_rd     <= '0;
            ex_f3     <= '0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
            ex_wb     <= 1'b0;
        end else if (!stall_o) begin
            ex_alu    <= alu_i;
            ex_wdata  <= wdata_i;
            ex_rd     <= rd_i;
            ex_f3     <= f3_i;
            ex_mem_rd <= valid_i & mem_rd_i;
            ex_mem_wr <= valid_i & mem_wr_i;
            ex_wb     <= valid_i & wb_reg_wr_i;
        end
    end

    assign memop = ex_mem_rd | ex_mem_wr;

    always_comb begin
        misaligned = 1'b0;
        st_be      = 4'b1111;
        st_data    = ex_wdata;
        case (ex_f3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << ex_alu[1:0];
                st_data = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = ex_alu[0];
                st_be      = ex_alu[1] ? 4'b1100 : 4'b0011;
                st_data    = {2{ex_wdata[15:0]}};
            end
            default: misaligned = |ex_alu[1:0];
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata_i[7:0];
        case (ex_alu[1:0])
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            2'd3:    ld_byte = dmem_rdata_i[31:24];
            default: ld_byte = dmem_rdata_i[7:0];
        endcase
        ld_half = ex_alu[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (ex_f3)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        dmem_req_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                if (dmem_ack_i) begin
                    state_d = S_DONE;
                end else if (cnt_q == LIMIT) begin
                    bus_err_o = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A store wins when both mem_rd and mem_wr are set.
    assign dmem_we_o    = dmem_req_o & ex_mem_wr;
    assign dmem_addr_o  = dmem_req_o ? {ex_alu[31:2], 2'b00} : 32'h0;
    assign dmem_be_o    = dmem_req_o ? (ex_mem_wr ? st_be : 4'b1111) : 4'b0000;
    assign dmem_wdata_o = (dmem_req_o & ex_mem_wr) ? st_data : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (dmem_ack_i)  ld_data_q <= ld_fmt;
                    else if (bus_err_o) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // MEM/WB writes every cycle; while stalled it carries a bubble so nothing commits twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_rd_o        <= '0;
            memwb_wdata_o     <= '0;
            memwb_wb_reg_wr_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stall_o) begin
                        memwb_wb_reg_wr_o <= 1'b0;
                    end else begin
                        memwb_rd_o        <= ex_rd;
                        memwb_wdata_o     <= ex_alu;
                        memwb_wb_reg_wr_o <= ex_wb & ~misalign_o;
                    end
                end
                S_DONE: begin
                    memwb_rd_o        <= ex_rd;
                    memwb_wdata_o     <= (ex_mem_rd & ~ex_mem_wr) ? ld_data_q : ex_alu;
                    memwb_wb_reg_wr_o <= ex_wb & ~err_q;
                end
                default: memwb_wb_reg_wr_o <= 1'b0;
            endcase
        end
    end

    assign exmem_rd_o        = ex_rd;
    assign exmem_alu_o       = ex_alu;
    assign exmem_wb_reg_wr_o = ex_wb;
    assign dbg_state         = state_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Holds the EX/MEM register. Performs data-memory loads and stores over a req/ack handshake, with load extension, store byte lanes and an access timeout.
- Holds the MEM/WB register. Exports both registers' rd, data and write-enable to the execute stage's forwarding inputs.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 16, max cycles in ACCESS waiting for dmem_ack_i before abort (≥2).

Ports:
- clk  in  1  stage clock
- rst  in  1  reset, asynchronous, active-low
- valid_i  in  1  EX result valid (0 = bubble)
- alu_i  in  32  ALU result / effective address
- wdata_i  in  32  store data (forwarded rs2)
- rd_i  in  5  destination register
- f3_i  in  3  funct3 (load/store width and sign)
- mem_rd_i  in  1  instruction is a load
- mem_wr_i  in  1  instruction is a store
- wb_reg_wr_i  in  1  instruction writes rd
- stall_o  out  1  hold upstream stages and EX/MEM input
- exmem_rd_o  out  5  EX/MEM rd, to forwarding
- exmem_alu_o  out  32  EX/MEM alu, to forwarding
- exmem_wb_reg_wr_o  out  1  EX/MEM write-enable, to forwarding
- memwb_rd_o  out  5  MEM/WB rd
- memwb_wdata_o  out  32  MEM/WB write-back data
- memwb_wb_reg_wr_o  out  1  MEM/WB write-enable
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address {alu[31:2],2'b00}
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_rdata_i  in  32  read data, valid with ack
- dmem_ack_i  in  1  access complete
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: ack timeout

Behaviour:
- Reset (rst=0, async): all registers, outputs and FSM clear; state=IDLE; all write-enables 0; dmem_req_o=0.
- EX/MEM register loads all inputs on each clk edge when stall_o=0. The registered valid is ANDed into every control bit; valid_i=0 loads a bubble.
- memop = EX/MEM valid & (mem_rd|mem_wr).
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
- FSM IDLE:
  - memop and aligned: stall_o=1; next state ACCESS; timeout counter cleared.
  - memop and misaligned: no request; misalign_o=1 this cycle; MEM/WB gets wb_reg_wr=0; stall_o=0.
  - no memop: stall_o=0; MEM/WB gets {rd, alu, wb_reg_wr}.
- FSM ACCESS:
  - dmem_req_o=1; we/addr/wdata/be held stable; stall_o=1.
  - dmem_ack_i=1: capture formatted load data; next state DONE.
  - No ack after ACK_TIMEOUT ACCESS cycles: bus_err_o pulse; MEM/WB wb_reg_wr=0; next state DONE.
- FSM DONE:
  - stall_o=0; MEM/WB gets {rd, load data or alu, wb_reg_wr}.
  - Next state IDLE, with a new EX/MEM entry loaded.
- Latency:
  - Non-memory instruction: 1 cycle in stage.
  - Memory instruction: IDLE + N ACCESS + DONE = N+2 cycles, N≥1.
- Loads, with b = addr[1:0]:
  - LB(000): sign-extend byte b.
  - LH(001): sign-extend halfword addr[1].
  - LW(010): full word.
  - LBU(100): zero-extend byte b.
  - LHU(101): zero-extend halfword addr[1].
  - Other f3: treated as LW.
- Stores:
  - SB: be=0001<<b, data={4{byte}}.
  - SH: be=0011<<(2*addr[1]), data={2{half}}.
  - SW: be=1111.
- Loads drive be=1111 and we=0.
- dmem_ack_i outside ACCESS is ignored.
- mem_rd & mem_wr both set: treated as a store.
- While stall_o=1, MEM/WB holds a bubble (wb_reg_wr=0) from the cycle after the previous commit, and never repeats a write.
- Reset asserted mid-access drops the request immediately. No write-back occurs.

Test Plan:
- ALU op, rd=5, alu=0x0000_1234, wb=1 -> next cycle memwb_rd_o=5, memwb_wdata_o=0x1234, wb=1, stall_o never high.
- LB addr=0x103, dmem_rdata_i=0x80_00_00_00, ack on 2nd ACCESS cycle:
  - dmem_req_o high 2 cycles; addr=0x100; stall_o high 3 cycles.
  - memwb_wdata_o=0xFFFF_FF80.
  - LBU same input gives 0x0000_0080.
- SH addr=0x202, wdata=0x0000_BEEF -> dmem_we_o=1, be=1100, dmem_wdata_o=0xBEEF_BEEF; memwb_wb_reg_wr_o=0.
- LW addr=0x101 -> no dmem_req_o; misalign_o one-cycle pulse; memwb_wb_reg_wr_o=0; no stall.
- LW, ack never arrives, ACK_TIMEOUT=16 -> req high exactly 16 cycles; bus_err_o pulse; no write-back; pipeline resumes.
- Reset mid-access:
  - rst low during ACCESS -> dmem_req_o=0 immediately; state IDLE; all outputs 0.
  - After rst high, a queued ALU op completes normally.
